// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared constants and state encodings for the 3-byte UART word link (receive and transmit sides).
package uart_pkg;

    localparam int         CLK_HZ_DEFAULT = 20_000_000;
    localparam int         BAUD_DEFAULT   = 500_000;
    localparam logic [7:0] UART_HEADER    = 8'd123;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    typedef enum logic [2:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP,
        BIT_BREAK
    } bit_state_t;

    typedef enum logic [1:0] {
        FRAME_HUNT,
        FRAME_HI,
        FRAME_LO
    } frame_state_t;

endpackage

// File: rtl/uart_frame_rx_if.sv
`timescale 1ns/1ps
// Received-word bundle: the assembled word and its status strobes.
interface uart_frame_rx_if;
    logic [15:0] data;
    logic        data_rdy;
    logic        frame_err;
    logic        timeout;

    modport master (output data, data_rdy, frame_err, timeout);
    modport slave  (input  data, data_rdy, frame_err, timeout);
endinterface

// File: rtl/uart_rx_byte.sv
`timescale 1ns/1ps
// 8N1 byte receiver: synchroniser, mid-bit sampling FSM and shift register.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 40
) (
    input  logic       clk_20m,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       stop_err,
    output logic       busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    bit_state_t       state;
    bit_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic [7:0]       byte_nxt;
    logic             vld_nxt;
    logic             err_nxt;

    // Preset to idle-high so a reset never looks like a start edge.
    always_ff @(posedge clk_20m) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk_20m) begin
        if (rst) begin
            state    <= BIT_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_byte  <= '0;
            byte_vld <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            rx_byte  <= byte_nxt;
            byte_vld <= vld_nxt;
            stop_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        byte_nxt    = rx_byte;
        vld_nxt     = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            BIT_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    cnt_nxt   = '0;
                    state_nxt = BIT_START;
                end
            end
            BIT_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (rx_sync) begin
                        state_nxt = BIT_IDLE;
                    end else begin
                        bit_idx_nxt = '0;
                        state_nxt   = BIT_DATA;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BIT_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_sync, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = BIT_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BIT_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt = '0;
                    if (rx_sync) begin
                        byte_nxt  = shreg;
                        vld_nxt   = 1'b1;
                        state_nxt = BIT_IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = BIT_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BIT_BREAK: begin
                // Holding here makes a stuck-low line report a single framing error.
                if (rx_sync) begin
                    state_nxt = BIT_IDLE;
                end
            end
            default: begin
                state_nxt = BIT_IDLE;
            end
        endcase
    end

    assign busy = (state != BIT_IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
`timescale 1ns/1ps
// Frame receiver: hunts for the header byte, assembles {hi, lo} and drops stalled frames.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int         CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int         BAUD         = BAUD_DEFAULT,
    parameter logic [7:0] HEADER       = UART_HEADER,
    parameter int         TIMEOUT_BITS = 40
) (
    input  logic             clk_20m,
    input  logic             rst,
    input  logic             rx,
    uart_frame_rx_if.master  word_if
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int               GAP_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int               GAP_W        = $clog2(GAP_LIMIT);
    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_LIMIT - 1);

    logic [7:0]       rx_byte;
    logic             byte_vld;
    logic             stop_err;
    logic             busy;

    frame_state_t     state;
    frame_state_t     state_nxt;
    logic [7:0]       hi;
    logic [7:0]       hi_nxt;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_nxt;
    logic [15:0]      data_q;
    logic [15:0]      data_nxt;
    logic             rdy_q;
    logic             rdy_nxt;
    logic             ferr_q;
    logic             to_q;
    logic             to_nxt;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk_20m  (clk_20m),
        .rst      (rst),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .stop_err (stop_err),
        .busy     (busy)
    );

    always_ff @(posedge clk_20m) begin
        if (rst) begin
            state  <= FRAME_HUNT;
            hi     <= '0;
            gap    <= '0;
            data_q <= '0;
            rdy_q  <= 1'b0;
            ferr_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            hi     <= hi_nxt;
            gap    <= gap_nxt;
            data_q <= data_nxt;
            rdy_q  <= rdy_nxt;
            ferr_q <= stop_err;
            to_q   <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hi_nxt    = hi;
        gap_nxt   = gap;
        data_nxt  = data_q;
        rdy_nxt   = 1'b0;
        to_nxt    = 1'b0;

        case (state)
            FRAME_HUNT: begin
                if (byte_vld && (rx_byte == HEADER)) begin
                    state_nxt = FRAME_HI;
                end
            end
            FRAME_HI: begin
                // A header value here is payload, not a resync.
                if (byte_vld) begin
                    hi_nxt    = rx_byte;
                    state_nxt = FRAME_LO;
                end else if (stop_err) begin
                    state_nxt = FRAME_HUNT;
                end
            end
            FRAME_LO: begin
                if (byte_vld) begin
                    data_nxt  = {hi, rx_byte};
                    rdy_nxt   = 1'b1;
                    state_nxt = FRAME_HUNT;
                end else if (stop_err) begin
                    state_nxt = FRAME_HUNT;
                end
            end
            default: begin
                state_nxt = FRAME_HUNT;
            end
        endcase

        // Inter-byte gap only counts while a frame is open and the line is quiet; a byte wins a tie.
        if ((state == FRAME_HUNT) || busy || byte_vld) begin
            gap_nxt = '0;
        end else if (gap == GAP_LAST) begin
            gap_nxt   = '0;
            to_nxt    = 1'b1;
            state_nxt = FRAME_HUNT;
        end else begin
            gap_nxt = gap + 1'b1;
        end
    end

    assign word_if.data      = data_q;
    assign word_if.data_rdy  = rdy_q;
    assign word_if.frame_err = ferr_q;
    assign word_if.timeout   = to_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_frame_rx: serialises frames onto rx and scores the received words.
module tb_uart_frame_rx;
    import uart_pkg::*;

    localparam int         CPB = 40;
    localparam logic [7:0] HDR = UART_HEADER;

    logic clk_20m = 1'b0;
    logic rst     = 1'b1;
    logic rx      = 1'b1;

    uart_frame_rx_if word_if ();

    uart_frame_rx dut (
        .clk_20m (clk_20m),
        .rst     (rst),
        .rx      (rx),
        .word_if (word_if)
    );

    always #25 clk_20m = ~clk_20m;

    int          assert_cnt = 0;
    int          fail_cnt   = 0;
    int          rdy_cnt    = 0;
    int          ferr_cnt   = 0;
    int          to_cnt     = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    // Scoreboard: every data_rdy pops the oldest expected word.
    always @(negedge clk_20m) begin
        if (word_if.frame_err === 1'b1) ferr_cnt++;
        if (word_if.timeout === 1'b1) to_cnt++;
        if (word_if.data_rdy === 1'b1) begin
            rdy_cnt++;
            assert_cnt++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("[TB] FAIL unexpected_rdy: got data=%h, expected no word", word_if.data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (word_if.data !== mon_exp) begin
                    fail_cnt++;
                    $display("[TB] FAIL word_data: got %h, expected %h", word_if.data, mon_exp);
                end
            end
            assert_cnt++;
            if ((word_if.frame_err !== 1'b0) || (word_if.timeout !== 1'b0)) begin
                fail_cnt++;
                $display("[TB] FAIL strobe_overlap: frame_err=%b timeout=%b, expected 0 0", word_if.frame_err, word_if.timeout);
            end
        end
    end

    initial begin
        #(60000 * 50);
        $display("[TB] FAIL watchdog: run exceeded %0d cycles, expected to finish earlier", 60000);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_20m);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [15:0] w, input int gap);
        send_byte(HDR, 1'b1);
        idle(gap);
        send_byte(w[15:8], 1'b1);
        idle(gap);
        send_byte(w[7:0], 1'b1);
        idle(gap);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk_20m);
        end
        idle(4);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        idle(5);
        assert_cnt++;
        if (word_if.data !== 16'h0000) begin
            fail_cnt++; $display("[TB] FAIL reset_data: got %h, expected 0000", word_if.data);
        end
        assert_cnt++;
        if ({word_if.data_rdy, word_if.frame_err, word_if.timeout} !== 3'b000) begin
            fail_cnt++;
            $display("[TB] FAIL reset_strobes: got %b%b%b, expected 000", word_if.data_rdy, word_if.frame_err, word_if.timeout);
        end
        rst = 1'b0;
        idle(5);
        assert_cnt++;
        if ((rdy_cnt + ferr_cnt + to_cnt) != 0) begin
            fail_cnt++; $display("[TB] FAIL reset_release: got %0d strobes, expected 0", rdy_cnt + ferr_cnt + to_cnt);
        end
    endtask

    task automatic test_basic;
        int r0 = rdy_cnt; int f0 = ferr_cnt; int t0 = to_cnt;
        exp_q.push_back(16'h1234);
        send_frame(16'h1234, CPB);
        wait_drain(400);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++; $display("[TB] FAIL basic_drain: got %0d pending, expected 0", exp_q.size());
        end
        assert_cnt++;
        if ((rdy_cnt - r0) != 1) begin
            fail_cnt++; $display("[TB] FAIL basic_rdy_count: got %0d, expected 1", rdy_cnt - r0);
        end
        assert_cnt++;
        if ((ferr_cnt != f0) || (to_cnt != t0)) begin
            fail_cnt++; $display("[TB] FAIL basic_errors: got ferr=%0d to=%0d, expected 0 0", ferr_cnt - f0, to_cnt - t0);
        end
        assert_cnt++;
        if (word_if.data !== 16'h1234) begin
            fail_cnt++; $display("[TB] FAIL basic_data: got %h, expected 1234", word_if.data);
        end
    endtask

    task automatic test_hunt;
        int r0 = rdy_cnt;
        exp_q.push_back(16'hABCD);
        send_byte(8'h55, 1'b1);
        idle(CPB);
        send_frame(16'hABCD, CPB);
        wait_drain(400);
        assert_cnt++;
        if ((rdy_cnt - r0) != 1) begin
            fail_cnt++; $display("[TB] FAIL hunt_rdy_count: got %0d, expected 1", rdy_cnt - r0);
        end
        assert_cnt++;
        if (word_if.data !== 16'hABCD) begin
            fail_cnt++; $display("[TB] FAIL hunt_data: got %h, expected abcd", word_if.data);
        end
    endtask

    task automatic test_back_to_back;
        int r0 = rdy_cnt; int f0 = ferr_cnt;
        exp_q.push_back(16'h7B7B);
        send_frame({HDR, HDR}, CPB);
        exp_q.push_back(16'h00FF);
        send_frame(16'h00FF, 0);
        wait_drain(400);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++; $display("[TB] FAIL b2b_drain: got %0d pending, expected 0", exp_q.size());
        end
        assert_cnt++;
        if ((rdy_cnt - r0) != 2) begin
            fail_cnt++; $display("[TB] FAIL b2b_rdy_count: got %0d, expected 2", rdy_cnt - r0);
        end
        assert_cnt++;
        if (ferr_cnt != f0) begin
            fail_cnt++; $display("[TB] FAIL b2b_ferr: got %0d, expected 0", ferr_cnt - f0);
        end
        assert_cnt++;
        if (word_if.data !== 16'h00FF) begin
            fail_cnt++; $display("[TB] FAIL b2b_data: got %h, expected 00ff", word_if.data);
        end
    endtask

    task automatic test_frame_err;
        int r0 = rdy_cnt; int f0 = ferr_cnt;
        send_byte(HDR, 1'b1);
        idle(CPB);
        send_byte(8'h12, 1'b0);
        idle(200);
        rx = 1'b1;
        idle(2 * CPB);
        assert_cnt++;
        if ((ferr_cnt - f0) != 1) begin
            fail_cnt++; $display("[TB] FAIL ferr_count: got %0d, expected 1", ferr_cnt - f0);
        end
        assert_cnt++;
        if ((rdy_cnt != r0) || (word_if.data !== 16'h00FF)) begin
            fail_cnt++; $display("[TB] FAIL ferr_hold: got rdy=%0d data=%h, expected 0 00ff", rdy_cnt - r0, word_if.data);
        end
        exp_q.push_back(16'h5678);
        send_frame(16'h5678, CPB);
        wait_drain(400);
        assert_cnt++;
        if (((ferr_cnt - f0) != 1) || ((rdy_cnt - r0) != 1)) begin
            fail_cnt++; $display("[TB] FAIL ferr_recover: got ferr=%0d rdy=%0d, expected 1 1", ferr_cnt - f0, rdy_cnt - r0);
        end
        assert_cnt++;
        if (word_if.data !== 16'h5678) begin
            fail_cnt++; $display("[TB] FAIL ferr_data: got %h, expected 5678", word_if.data);
        end
    endtask

    task automatic test_timeout;
        int r0 = rdy_cnt; int t0 = to_cnt;
        send_byte(HDR, 1'b1);
        idle(CPB);
        send_byte(8'h12, 1'b1);
        idle(1500);
        assert_cnt++;
        if (to_cnt != t0) begin
            fail_cnt++; $display("[TB] FAIL timeout_early: got %0d pulses, expected 0", to_cnt - t0);
        end
        idle(200);
        assert_cnt++;
        if ((to_cnt - t0) != 1) begin
            fail_cnt++; $display("[TB] FAIL timeout_pulse: got %0d pulses, expected 1", to_cnt - t0);
        end
        assert_cnt++;
        if (rdy_cnt != r0) begin
            fail_cnt++; $display("[TB] FAIL timeout_rdy: got %0d, expected 0", rdy_cnt - r0);
        end
        exp_q.push_back(16'h9ABC);
        send_frame(16'h9ABC, CPB);
        wait_drain(400);
        assert_cnt++;
        if (word_if.data !== 16'h9ABC) begin
            fail_cnt++; $display("[TB] FAIL timeout_data: got %h, expected 9abc", word_if.data);
        end
    endtask

    task automatic test_glitch_reset;
        int r0 = rdy_cnt; int f0 = ferr_cnt; int t0 = to_cnt;
        rx = 1'b0;
        idle(10);
        rx = 1'b1;
        idle(3 * CPB);
        assert_cnt++;
        if ((rdy_cnt != r0) || (ferr_cnt != f0) || (to_cnt != t0) || (word_if.data !== 16'h9ABC)) begin
            fail_cnt++;
            $display("[TB] FAIL glitch: got rdy=%0d ferr=%0d to=%0d data=%h, expected 0 0 0 9abc",
                     rdy_cnt - r0, ferr_cnt - f0, to_cnt - t0, word_if.data);
        end
        send_byte(HDR, 1'b1);
        idle(CPB);
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(CPB);
        rx = 1'b0;
        idle(CPB / 2);
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        assert_cnt++;
        if (word_if.data !== 16'h0000) begin
            fail_cnt++; $display("[TB] FAIL midframe_reset_data: got %h, expected 0000", word_if.data);
        end
        assert_cnt++;
        if ({word_if.data_rdy, word_if.frame_err, word_if.timeout} !== 3'b000) begin
            fail_cnt++;
            $display("[TB] FAIL midframe_reset_strobes: got %b%b%b, expected 000", word_if.data_rdy, word_if.frame_err, word_if.timeout);
        end
        rst = 1'b0;
        idle(2500);
        assert_cnt++;
        if ((rdy_cnt != r0) || (ferr_cnt != f0) || (to_cnt != t0)) begin
            fail_cnt++;
            $display("[TB] FAIL post_reset_quiet: got rdy=%0d ferr=%0d to=%0d, expected 0 0 0", rdy_cnt - r0, ferr_cnt - f0, to_cnt - t0);
        end
        exp_q.push_back(16'h0102);
        send_frame(16'h0102, CPB);
        wait_drain(400);
        assert_cnt++;
        if ((word_if.data !== 16'h0102) || (exp_q.size() != 0)) begin
            fail_cnt++; $display("[TB] FAIL post_reset_data: got %h pending=%0d, expected 0102 0", word_if.data, exp_q.size());
        end
    endtask

    initial begin
        $display("[TB] starting uart_frame_rx bench");
        test_reset();
        test_basic();
        test_hunt();
        test_back_to_back();
        test_frame_err();
        test_timeout();
        test_glitch_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
